mmio_ctrl: RTL and testbench

Memory-mapped I/O controller between the CPU's memory port and the on-chip RAM, slide switches and red LEDs of the lab top level. It decodes each CPU access by address, routes it to RAM, the switch input or the LED register, and returns read data with the same one-cycle latency as the synchronous RAM. It also synchronises and debounces the raw switch inputs, and flags illegal accesses with a sticky error bit.

---
 rtl/mmio_ctrl_pkg.sv | 21 ++
 rtl/mmio_ctrl_if.sv | 26 ++
 rtl/mmio_ctrl_sw_debounce.sv | 40 ++++
 rtl/mmio_ctrl.sv | 90 +++++++++
 tb/tb_mmio_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_ctrl_pkg.sv
// Shared definitions for the lab MMIO controller and its CPU.
package mmio_ctrl_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 16;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam logic [8:0] LED_ADDR_DEF = 9'h100;
    localparam logic [8:0] SW_ADDR_DEF  = 9'h140;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_LED,
        SEL_SW
    } sel_e;

endpackage

// File: rtl/mmio_ctrl_if.sv
// CPU memory port bundle: command, address and data in both directions.
interface mmio_ctrl_if
    import mmio_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;

    modport master (
        output mem_cmd,
        output mem_addr,
        output write_data,
        input  read_data
    );

    modport slave (
        input  mem_cmd,
        input  mem_addr,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/mmio_ctrl_sw_debounce.sv
// Two-flop synchroniser followed by a stability counter for slide switches.
module sw_debounce #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_stable
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] cand;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1        <= '0;
            s2        <= '0;
            cand      <= '0;
            cnt       <= '0;
            sw_stable <= '0;
        end else begin
            s1 <= sw_in;
            s2 <= s1;
            // any change at s2 restarts the stability window
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt == CNT_LAST) begin
                sw_stable <= cand;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/mmio_ctrl.sv
// Address decode for RAM, LED register and switches with one-cycle read data.
module mmio_ctrl
    import mmio_ctrl_pkg::*;
#(
    parameter int               ADDR_W          = ADDR_W_DEF,
    parameter int               DATA_W          = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] LED_ADDR       = LED_ADDR_DEF,
    parameter logic [ADDR_W-1:0] SW_ADDR        = SW_ADDR_DEF,
    parameter int               DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    mmio_ctrl_if.slave        bus,
    output logic [7:0]        ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [7:0]        sw_in,
    output logic [7:0]        ledr,
    output logic              bad_access
);
    logic [7:0] sw_stable;
    sel_e       sel_d;
    sel_e       sel_q;
    logic       is_ram;
    logic       is_led;
    logic       is_sw;
    logic       is_rd;
    logic       is_wr;
    logic       bad_d;

    sw_debounce #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
        .clk       (clk),
        .reset     (reset),
        .sw_in     (sw_in),
        .sw_stable (sw_stable)
    );

    assign is_ram = ~bus.mem_addr[ADDR_W-1];
    assign is_led = bus.mem_addr == LED_ADDR;
    assign is_sw  = bus.mem_addr == SW_ADDR;
    assign is_rd  = bus.mem_cmd == MREAD;
    assign is_wr  = bus.mem_cmd == MWRITE;

    assign ram_addr  = bus.mem_addr[7:0];
    assign ram_wdata = bus.write_data;
    assign ram_we    = is_wr & is_ram;

    always_comb begin
        sel_d = SEL_NONE;
        if (is_rd) begin
            unique case (1'b1)
                is_ram:  sel_d = SEL_RAM;
                is_led:  sel_d = SEL_LED;
                is_sw:   sel_d = SEL_SW;
                default: sel_d = SEL_NONE;
            endcase
        end
    end

    // 2'b11 behaves as MNONE but is still reported
    assign bad_d = (is_wr & is_sw)
                 | ((is_rd | is_wr) & ~is_ram & ~is_led & ~is_sw)
                 | (bus.mem_cmd == 2'b11);

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q      <= SEL_NONE;
            ledr       <= '0;
            bad_access <= 1'b0;
        end else begin
            sel_q <= sel_d;
            if (is_wr & is_led) ledr <= bus.write_data[7:0];
            if (bad_d) bad_access <= 1'b1;
        end
    end

    always_comb begin
        bus.read_data = '0;
        unique case (sel_q)
            SEL_RAM:  bus.read_data = ram_rdata;
            SEL_LED:  bus.read_data = {{(DATA_W-8){1'b0}}, ledr};
            SEL_SW:   bus.read_data = {{(DATA_W-8){1'b0}}, sw_stable};
            default:  bus.read_data = '0;
        endcase
    end
endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed self-checking bench for mmio_ctrl with a behavioural RAM.
module tb_mmio_ctrl;
    import mmio_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic [7:0]  sw_in;
    logic [7:0]  ledr;
    logic        bad_access;
    logic [15:0] ram [256];

    int passed;
    int total;

    mmio_ctrl_if bus ();

    mmio_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .sw_in      (sw_in),
        .ledr       (ledr),
        .bad_access (bad_access)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] c, input logic [8:0] a,
                         input logic [15:0] d);
        bus.mem_cmd    = c;
        bus.mem_addr   = a;
        bus.write_data = d;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(MNONE, 9'h000, 16'h0000);
        sw_in = 8'h00;
        tick;
        tick;
        reset = 1'b0;
        #1;
        total++;
        if (ledr !== 8'h00) $display("FAIL reset_ledr got %h want 00", ledr);
        else passed++;
        total++;
        if (bus.read_data !== 16'h0000)
            $display("FAIL reset_rdata got %h want 0000", bus.read_data);
        else passed++;
        total++;
        if (bad_access !== 1'b0)
            $display("FAIL reset_bad got %b want 0", bad_access);
        else passed++;
        total++;
        if (ram_we !== 1'b0) $display("FAIL reset_we got %b want 0", ram_we);
        else passed++;
    endtask

    task automatic test_sw_led;
        sw_in = 8'd4;
        repeat (10) tick;
        drive(MREAD, SW_ADDR_DEF, 16'h0000);
        tick;
        drive(MWRITE, LED_ADDR_DEF, 16'h0008);
        #1;
        total++;
        if (bus.read_data !== 16'h0004)
            $display("FAIL sw_read got %h want 0004", bus.read_data);
        else passed++;
        total++;
        if (ram_we !== 1'b0) $display("FAIL led_we got %b want 0", ram_we);
        else passed++;
        tick;
        drive(MREAD, LED_ADDR_DEF, 16'h0000);
        #1;
        total++;
        if (ledr !== 8'h08) $display("FAIL led_wr got %h want 08", ledr);
        else passed++;
        tick;
        drive(MNONE, 9'h000, 16'h0000);
        #1;
        total++;
        if (bus.read_data !== 16'h0008)
            $display("FAIL led_read got %h want 0008", bus.read_data);
        else passed++;
        tick;
        total++;
        if (bus.read_data !== 16'h0000)
            $display("FAIL idle_read got %h want 0000", bus.read_data);
        else passed++;
    endtask

    task automatic test_ram;
        drive(MWRITE, 9'h010, 16'hABCD);
        #1;
        total++;
        if (ram_we !== 1'b1) $display("FAIL ram_we got %b want 1", ram_we);
        else passed++;
        total++;
        if (ram_addr !== 8'h10)
            $display("FAIL ram_addr got %h want 10", ram_addr);
        else passed++;
        total++;
        if (ram_wdata !== 16'hABCD)
            $display("FAIL ram_wdata got %h want abcd", ram_wdata);
        else passed++;
        tick;
        drive(MREAD, 9'h010, 16'h0000);
        #1;
        total++;
        if (ram_we !== 1'b0) $display("FAIL ram_rd_we got %b want 0", ram_we);
        else passed++;
        tick;
        drive(MNONE, 9'h000, 16'h0000);
        #1;
        total++;
        if (bus.read_data !== 16'hABCD)
            $display("FAIL ram_read got %h want abcd", bus.read_data);
        else passed++;
        tick;
    endtask

    task automatic test_back_to_back;
        drive(MWRITE, LED_ADDR_DEF, 16'h125A);
        tick;
        drive(MREAD, LED_ADDR_DEF, 16'h0000);
        tick;
        drive(MREAD, SW_ADDR_DEF, 16'h0000);
        #1;
        total++;
        if (bus.read_data !== 16'h005A)
            $display("FAIL b2b_led got %h want 005a", bus.read_data);
        else passed++;
        tick;
        drive(MREAD, 9'h010, 16'h0000);
        #1;
        total++;
        if (bus.read_data !== 16'h0004)
            $display("FAIL b2b_sw got %h want 0004", bus.read_data);
        else passed++;
        tick;
        drive(MNONE, 9'h010, 16'h0000);
        #1;
        total++;
        if (bus.read_data !== 16'hABCD)
            $display("FAIL b2b_ram got %h want abcd", bus.read_data);
        else passed++;
        tick;
        total++;
        if (bus.read_data !== 16'h0000)
            $display("FAIL b2b_none got %h want 0000", bus.read_data);
        else passed++;
    endtask

    task automatic test_debounce;
        sw_in = 8'h00;
        drive(MREAD, SW_ADDR_DEF, 16'h0000);
        repeat (10) tick;
        total++;
        if (bus.read_data !== 16'h0000)
            $display("FAIL sw_zero got %h want 0000", bus.read_data);
        else passed++;
        sw_in = 8'hFF;
        tick;
        tick;
        sw_in = 8'h00;
        for (int i = 0; i < 12; i++) begin
            tick;
            total++;
            if (bus.read_data !== 16'h0000)
                $display("FAIL glitch_%0d got %h want 0000", i, bus.read_data);
            else passed++;
        end
        sw_in = 8'hFF;
        repeat (6) tick;
        total++;
        if (bus.read_data !== 16'h0000)
            $display("FAIL sw_edge6 got %h want 0000", bus.read_data);
        else passed++;
        tick;
        total++;
        if (bus.read_data !== 16'h00FF)
            $display("FAIL sw_edge7 got %h want 00ff", bus.read_data);
        else passed++;
        drive(MNONE, 9'h000, 16'h0000);
        tick;
    endtask

    task automatic test_bad_access;
        total++;
        if (bad_access !== 1'b0)
            $display("FAIL bad_pre got %b want 0", bad_access);
        else passed++;
        drive(MWRITE, SW_ADDR_DEF, 16'h1234);
        #1;
        total++;
        if (ram_we !== 1'b0) $display("FAIL bad_sw_we got %b want 0", ram_we);
        else passed++;
        tick;
        drive(MNONE, 9'h1F0, 16'h0000);
        #1;
        total++;
        if (bad_access !== 1'b1)
            $display("FAIL bad_swwr got %b want 1", bad_access);
        else passed++;
        total++;
        if (ledr !== 8'h5A) $display("FAIL bad_ledr got %h want 5a", ledr);
        else passed++;
        tick;
        drive(MREAD, 9'h1F0, 16'h0000);
        tick;
        drive(2'b11, 9'h010, 16'h7777);
        #1;
        total++;
        if (ram_we !== 1'b0) $display("FAIL bad_c3_we got %b want 0", ram_we);
        else passed++;
        tick;
        drive(MREAD, 9'h010, 16'h0000);
        #1;
        total++;
        if (bad_access !== 1'b1)
            $display("FAIL bad_sticky got %b want 1", bad_access);
        else passed++;
        total++;
        if (bus.read_data !== 16'h0000)
            $display("FAIL bad_c3_rd got %h want 0000", bus.read_data);
        else passed++;
        tick;
        drive(MNONE, 9'h000, 16'h0000);
        #1;
        total++;
        if (bus.read_data !== 16'hABCD)
            $display("FAIL bad_ram got %h want abcd", bus.read_data);
        else passed++;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        total++;
        if (bad_access !== 1'b0)
            $display("FAIL bad_clr got %b want 0", bad_access);
        else passed++;
        drive(MREAD, 9'h1F0, 16'h0000);
        tick;
        drive(MNONE, 9'h000, 16'h0000);
        total++;
        if (bad_access !== 1'b1)
            $display("FAIL bad_rd_unmap got %b want 1", bad_access);
        else passed++;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        drive(2'b11, 9'h000, 16'h0000);
        tick;
        drive(MNONE, 9'h000, 16'h0000);
        total++;
        if (bad_access !== 1'b1)
            $display("FAIL bad_cmd3 got %b want 1", bad_access);
        else passed++;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        drive(MWRITE, 9'h1F0, 16'h0000);
        tick;
        drive(MNONE, 9'h1F0, 16'h0000);
        total++;
        if (bad_access !== 1'b1)
            $display("FAIL bad_wr_unmap got %b want 1", bad_access);
        else passed++;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        tick;
        drive(MREAD, LED_ADDR_DEF, 16'h0000);
        tick;
        drive(MREAD, SW_ADDR_DEF, 16'h0000);
        tick;
        drive(MNONE, 9'h000, 16'h0000);
        total++;
        if (bad_access !== 1'b0)
            $display("FAIL bad_false got %b want 0", bad_access);
        else passed++;
    endtask

    task automatic test_reset_write;
        drive(MWRITE, LED_ADDR_DEF, 16'h0033);
        tick;
        drive(MWRITE, LED_ADDR_DEF, 16'h00FF);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        drive(MNONE, 9'h000, 16'h0000);
        total++;
        if (ledr !== 8'h00) $display("FAIL rst_wr got %h want 00", ledr);
        else passed++;
        drive(MWRITE, LED_ADDR_DEF, 16'h0033);
        tick;
        drive(MREAD, LED_ADDR_DEF, 16'h0000);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        drive(MNONE, 9'h000, 16'h0000);
        total++;
        if (bus.read_data !== 16'h0000)
            $display("FAIL rst_rd got %h want 0000", bus.read_data);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
        test_reset;
        test_sw_led;
        test_ram;
        test_back_to_back;
        test_debounce;
        test_bad_access;
        test_reset_write;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
